morse_decoder: RTL

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/morse_decoder.sv
// Morse character decoder: packed dot/dash code -> ASCII, buffered in a show-ahead FIFO.
// Define MORSE_DECODER_SPACE_EN to insert 0x20 on inter-word gaps; otherwise interword is ignored.
module morse_decoder #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] code_in,
  input  logic       code_valid,
  input  logic       interword,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       full,
  output logic       err,
  output logic       lost
);

`ifdef MORSE_DECODER_SPACE_EN
  localparam bit SpaceEn = 1'b1;
`else
  localparam bit SpaceEn = 1'b0;
`endif

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW+1)'(1);
  localparam logic [AW:0]   CntMax = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_DECODE     = 2'd1;
  localparam logic [1:0] S_PUSH_CHAR  = 2'd2;
  localparam logic [1:0] S_PUSH_SPACE = 2'd3;

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("morse_decoder: DEPTH must be a power of two in 2..64");
  end

  // Any code not listed (invalid slot layout or unmapped pattern) falls to '?' with bad=1.
  function automatic logic [8:0] lookup(input logic [9:0] c);
    logic       bad;
    logic [7:0] ch;
    bad = 1'b0;
    ch  = 8'h3F;
    case (c)
      10'h009: ch = 8'h41; // A .-
      10'h056: ch = 8'h42; // B -...
      10'h066: ch = 8'h43; // C -.-.
      10'h016: ch = 8'h44; // D -..
      10'h001: ch = 8'h45; // E .
      10'h065: ch = 8'h46; // F ..-.
      10'h01A: ch = 8'h47; // G --.
      10'h055: ch = 8'h48; // H ....
      10'h005: ch = 8'h49; // I ..
      10'h0A9: ch = 8'h4A; // J .---
      10'h026: ch = 8'h4B; // K -.-
      10'h059: ch = 8'h4C; // L .-..
      10'h00A: ch = 8'h4D; // M --
      10'h006: ch = 8'h4E; // N -.
      10'h02A: ch = 8'h4F; // O ---
      10'h069: ch = 8'h50; // P .--.
      10'h09A: ch = 8'h51; // Q --.-
      10'h019: ch = 8'h52; // R .-.
      10'h015: ch = 8'h53; // S ...
      10'h002: ch = 8'h54; // T -
      10'h025: ch = 8'h55; // U ..-
      10'h095: ch = 8'h56; // V ...-
      10'h029: ch = 8'h57; // W .--
      10'h096: ch = 8'h58; // X -..-
      10'h0A6: ch = 8'h59; // Y -.--
      10'h05A: ch = 8'h5A; // Z --..
      10'h2AA: ch = 8'h30; // 0 -----
      10'h2A9: ch = 8'h31; // 1 .----
      10'h2A5: ch = 8'h32; // 2 ..---
      10'h295: ch = 8'h33; // 3 ...--
      10'h255: ch = 8'h34; // 4 ....-
      10'h155: ch = 8'h35; // 5 .....
      10'h156: ch = 8'h36; // 6 -....
      10'h15A: ch = 8'h37; // 7 --...
      10'h16A: ch = 8'h38; // 8 ---..
      10'h1AA: ch = 8'h39; // 9 ----.
      default: bad = 1'b1;
    endcase
    return {bad, ch};
  endfunction

  logic [1:0]    state_q, state_d;
  logic [9:0]    code_q, code_d;
  logic [7:0]    char_q, char_d;
  logic          err_q, err_d;
  logic          lost_q, lost_d;
  logic          space_pend_q, space_pend_d;
  logic          pushed_any_q, pushed_any_d;
  logic          last_sp_q, last_sp_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic          lut_bad;
  logic [7:0]    lut_ch;
  logic          push_req;
  logic [7:0]    push_data;
  logic          in_drop;
  logic          pop, wr_en, push_lost;
  logic          char_inflight, space_ok;

  assign {lut_bad, lut_ch} = lookup(code_q);

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    char_d    = char_q;
    err_d     = err_q;
    push_req  = 1'b0;
    push_data = char_q;
    case (state_q)
      S_IDLE: begin
        if (code_valid) begin
          code_d  = code_in;
          state_d = S_DECODE;
        end else if (space_pend_q) begin
          state_d = S_PUSH_SPACE;
        end
      end
      S_DECODE: begin
        char_d  = lut_ch;
        err_d   = err_q | lut_bad;
        state_d = S_PUSH_CHAR;
      end
      S_PUSH_CHAR: begin
        push_req  = 1'b1;
        push_data = char_q;
        state_d   = S_IDLE;
      end
      S_PUSH_SPACE: begin
        push_req  = 1'b1;
        push_data = 8'h20;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_drop = code_valid && (state_q != S_IDLE);

  // A gap is worth a space only if a non-space char precedes it; a char still in flight counts.
  assign char_inflight = (state_q == S_IDLE && code_valid) || (state_q == S_DECODE) ||
                         (state_q == S_PUSH_CHAR);
  assign space_ok      = char_inflight ||
                         (pushed_any_q && !last_sp_q && state_q != S_PUSH_SPACE);

  always_comb begin
    space_pend_d = space_pend_q;
    pushed_any_d = pushed_any_q;
    last_sp_d    = last_sp_q;
    if (SpaceEn && interword && space_ok) space_pend_d = 1'b1;
    if (state_q == S_PUSH_SPACE)          space_pend_d = 1'b0;
    if (push_req) begin
      pushed_any_d = 1'b1;
      last_sp_d    = (push_data == 8'h20);
    end
  end

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CntMax);
  assign pop       = out_valid && out_ready;
  // Full with a same-cycle pop still has a free slot at the edge.
  assign wr_en     = push_req && (!full || pop);
  assign push_lost = push_req && full && !pop;
  assign lost_d    = lost_q | in_drop | push_lost;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + CntOne;
    else if (!wr_en && pop) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      char_q       <= '0;
      err_q        <= 1'b0;
      lost_q       <= 1'b0;
      space_pend_q <= 1'b0;
      pushed_any_q <= 1'b0;
      last_sp_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      char_q       <= char_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
      space_pend_q <= space_pend_d;
      pushed_any_q <= pushed_any_d;
      last_sp_q    <= last_sp_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // Gate the head with out_valid so an empty FIFO reads 0x00, including straight out of reset.
  assign out_data = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign err      = err_q;
  assign lost     = lost_q;

endmodule
